// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits, with an internal baud divider.
module uart_tx_param #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state, state_nx;
    logic [BAUD_W-1:0]   baud_cnt, baud_cnt_nx;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_nx;
    logic [DATA_W-1:0]   shreg, shreg_nx;
    logic                par_bit, par_bit_nx;
    logic                out_nx, busy_nx, done_nx;
    logic                bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            shreg    <= shreg_nx;
            par_bit  <= par_bit_nx;
            tx_out   <= out_nx;
            tx_busy  <= busy_nx;
            tx_done  <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        baud_cnt_nx = bit_end ? '0 : baud_cnt + 1'b1;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        par_bit_nx  = par_bit;
        out_nx      = tx_out;
        busy_nx     = tx_busy;
        done_nx     = 1'b0;

        case (state)
            IDLE: begin
                // Baud counter held at zero so every frame is aligned to its start edge.
                baud_cnt_nx = '0;
                out_nx      = 1'b1;
                busy_nx     = 1'b0;
                if (tx_start) begin
                    shreg_nx   = tx_data;
                    par_bit_nx = (PARITY_MODE == 2) ? ~(^tx_data) : ^tx_data;
                    bit_cnt_nx = '0;
                    state_nx   = START;
                    out_nx     = 1'b0;
                    busy_nx    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx   = DATA;
                    bit_cnt_nx = '0;
                    out_nx     = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_nx = '0;
                        if (PARITY_MODE != 0) begin
                            state_nx = PARITY;
                            out_nx   = par_bit;
                        end else begin
                            state_nx = STOP;
                            out_nx   = 1'b1;
                        end
                    end else begin
                        bit_cnt_nx = bit_cnt + 1'b1;
                        shreg_nx   = shreg >> 1;
                        out_nx     = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nx   = STOP;
                    bit_cnt_nx = '0;
                    out_nx     = 1'b1;
                end
            end
            STOP: begin
                // bit_cnt is reused here to count stop bits.
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_nx   = IDLE;
                        bit_cnt_nx = '0;
                        busy_nx    = 1'b0;
                        done_nx    = 1'b1;
                    end else begin
                        bit_cnt_nx = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                out_nx   = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param using three parameter sets with
// hand-computed line sequences.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       a_start = 1'b0, a_out, a_busy, a_done;
    logic [7:0] a_data  = '0;
    logic       b_start = 1'b0, b_out, b_busy, b_done;
    logic [7:0] b_data  = '0;
    logic       c_start = 1'b0, c_out, c_busy, c_done;
    logic [6:0] c_data  = '0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_start(a_start), .tx_data(a_data),
        .tx_out(a_out), .tx_busy(a_busy), .tx_done(a_done));

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_start(b_start), .tx_data(b_data),
        .tx_out(b_out), .tx_busy(b_busy), .tx_done(b_done));

    uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(3), .PARITY_MODE(0), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .tx_start(c_start), .tx_data(c_data),
        .tx_out(c_out), .tx_busy(c_busy), .tx_done(c_done));

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({a_out, a_busy, a_done, b_out, b_busy, b_done, c_out, c_busy, c_done} !== 9'b100_100_100) begin
            miscompares++;
            $display("FAIL reset_state got=%b want=100100100",
                     {a_out, a_busy, a_done, b_out, b_busy, b_done, c_out, c_busy, c_done});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Slots: start | A5 LSB first | even parity 0 | stop
    task automatic test_basic_even;
        logic [0:10] exp;
        exp = 11'b0_10100101_0_1;
        a_start = 1'b1; a_data = 8'hA5;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 44; i++) begin
            vectors++;
            if ({a_out, a_busy, a_done} !== {exp[i/4], 2'b10}) begin
                miscompares++;
                $display("FAIL even_a5 cyc=%0d got=%b want=%b", i, {a_out, a_busy, a_done}, {exp[i/4], 2'b10});
            end
            @(negedge clk);
        end
        vectors++;
        if ({a_out, a_busy, a_done} !== 3'b101) begin
            miscompares++;
            $display("FAIL even_a5_done got=%b want=101", {a_out, a_busy, a_done});
        end
        @(negedge clk);
        vectors++;
        if ({a_out, a_busy, a_done} !== 3'b100) begin
            miscompares++;
            $display("FAIL even_a5_idle got=%b want=100", {a_out, a_busy, a_done});
        end
    endtask

    // Slots: start | 8 zeros | odd parity 1 | stop | stop
    task automatic test_odd_two_stop;
        logic [0:11] exp;
        exp = 12'b0_00000000_1_11;
        b_start = 1'b1; b_data = 8'h00;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            vectors++;
            if ({b_out, b_busy, b_done} !== {exp[i/4], 2'b10}) begin
                miscompares++;
                $display("FAIL odd_2stop cyc=%0d got=%b want=%b", i, {b_out, b_busy, b_done}, {exp[i/4], 2'b10});
            end
            @(negedge clk);
        end
        vectors++;
        if ({b_out, b_busy, b_done} !== 3'b101) begin
            miscompares++;
            $display("FAIL odd_2stop_done got=%b want=101", {b_out, b_busy, b_done});
        end
        @(negedge clk);
    endtask

    // Slots: start | 41h LSB first (7 bits) | stop, no parity
    task automatic test_short_no_parity;
        logic [0:8] exp;
        exp = 9'b0_1000001_1;
        c_start = 1'b1; c_data = 7'h41;
        @(negedge clk);
        c_start = 1'b0;
        for (int i = 0; i < 27; i++) begin
            vectors++;
            if ({c_out, c_busy, c_done} !== {exp[i/3], 2'b10}) begin
                miscompares++;
                $display("FAIL short_41 cyc=%0d got=%b want=%b", i, {c_out, c_busy, c_done}, {exp[i/3], 2'b10});
            end
            @(negedge clk);
        end
        vectors++;
        if ({c_out, c_busy, c_done} !== 3'b101) begin
            miscompares++;
            $display("FAIL short_41_done got=%b want=101", {c_out, c_busy, c_done});
        end
        @(negedge clk);
    endtask

    // 3C = 0,0,1,1,1,1,0,0 LSB first, even parity 0; a second request arrives during data bit 3
    task automatic test_busy_lockout;
        logic [0:10] exp;
        exp = 11'b0_00111100_0_1;
        a_start = 1'b1; a_data = 8'h3C;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 44; i++) begin
            vectors++;
            if ({a_out, a_busy, a_done} !== {exp[i/4], 2'b10}) begin
                miscompares++;
                $display("FAIL lockout cyc=%0d got=%b want=%b", i, {a_out, a_busy, a_done}, {exp[i/4], 2'b10});
            end
            if (i == 16) begin a_start = 1'b1; a_data = 8'hFF; end
            if (i == 20) a_start = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if ({a_out, a_busy, a_done} !== 3'b101) begin
            miscompares++;
            $display("FAIL lockout_done got=%b want=101", {a_out, a_busy, a_done});
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vectors++;
            if ({a_out, a_busy, a_done} !== 3'b100) begin
                miscompares++;
                $display("FAIL lockout_after cyc=%0d got=%b want=100", i, {a_out, a_busy, a_done});
            end
        end
        @(negedge clk);
    endtask

    // 81h then 55h requested in the done cycle; both have even parity 0
    task automatic test_back_to_back;
        logic [0:10] exp1;
        logic [0:10] exp2;
        exp1 = 11'b0_10000001_0_1;
        exp2 = 11'b0_10101010_0_1;
        a_start = 1'b1; a_data = 8'h81;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 44; i++) begin
            vectors++;
            if ({a_out, a_busy, a_done} !== {exp1[i/4], 2'b10}) begin
                miscompares++;
                $display("FAIL b2b_81 cyc=%0d got=%b want=%b", i, {a_out, a_busy, a_done}, {exp1[i/4], 2'b10});
            end
            @(negedge clk);
        end
        vectors++;
        if ({a_out, a_busy, a_done} !== 3'b101) begin
            miscompares++;
            $display("FAIL b2b_gap got=%b want=101", {a_out, a_busy, a_done});
        end
        a_start = 1'b1; a_data = 8'h55;
        @(negedge clk);
        a_start = 1'b0; a_data = 8'h00;
        for (int i = 0; i < 44; i++) begin
            vectors++;
            if ({a_out, a_busy, a_done} !== {exp2[i/4], 2'b10}) begin
                miscompares++;
                $display("FAIL b2b_55 cyc=%0d got=%b want=%b", i, {a_out, a_busy, a_done}, {exp2[i/4], 2'b10});
            end
            @(negedge clk);
        end
        vectors++;
        if ({a_out, a_busy, a_done} !== 3'b101) begin
            miscompares++;
            $display("FAIL b2b_55_done got=%b want=101", {a_out, a_busy, a_done});
        end
        @(negedge clk);
    endtask

    // Continuous request on the 7-bit, no-parity instance
    task automatic test_held_start;
        logic [0:8] exp;
        exp = 9'b0_1000001_1;
        c_start = 1'b1; c_data = 7'h41;
        @(negedge clk);
        for (int i = 0; i < 27; i++) begin
            vectors++;
            if ({c_out, c_busy, c_done} !== {exp[i/3], 2'b10}) begin
                miscompares++;
                $display("FAIL held_1 cyc=%0d got=%b want=%b", i, {c_out, c_busy, c_done}, {exp[i/3], 2'b10});
            end
            @(negedge clk);
        end
        vectors++;
        if ({c_out, c_busy, c_done} !== 3'b101) begin
            miscompares++;
            $display("FAIL held_gap got=%b want=101", {c_out, c_busy, c_done});
        end
        @(negedge clk);
        c_start = 1'b0;
        for (int i = 0; i < 27; i++) begin
            vectors++;
            if ({c_out, c_busy, c_done} !== {exp[i/3], 2'b10}) begin
                miscompares++;
                $display("FAIL held_2 cyc=%0d got=%b want=%b", i, {c_out, c_busy, c_done}, {exp[i/3], 2'b10});
            end
            @(negedge clk);
        end
        vectors++;
        if ({c_out, c_busy, c_done} !== 3'b101) begin
            miscompares++;
            $display("FAIL held_2_done got=%b want=101", {c_out, c_busy, c_done});
        end
        @(negedge clk);
    endtask

    task automatic test_mid_frame_reset;
        logic [0:10] exp;
        exp = 11'b0_00111100_0_1;
        a_start = 1'b1; a_data = 8'hA5;
        @(negedge clk);
        a_start = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if ({a_out, a_busy, a_done} !== 3'b010) begin
            miscompares++;
            $display("FAIL rst_pre got=%b want=010", {a_out, a_busy, a_done});
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({a_out, a_busy, a_done} !== 3'b100) begin
            miscompares++;
            $display("FAIL rst_async got=%b want=100", {a_out, a_busy, a_done});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            vectors++;
            if ({a_out, a_busy, a_done} !== 3'b100) begin
                miscompares++;
                $display("FAIL rst_hold cyc=%0d got=%b want=100", i, {a_out, a_busy, a_done});
            end
        end
        @(negedge clk);
        a_start = 1'b1; a_data = 8'h3C;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 44; i++) begin
            vectors++;
            if ({a_out, a_busy, a_done} !== {exp[i/4], 2'b10}) begin
                miscompares++;
                $display("FAIL rst_after cyc=%0d got=%b want=%b", i, {a_out, a_busy, a_done}, {exp[i/4], 2'b10});
            end
            @(negedge clk);
        end
        vectors++;
        if ({a_out, a_busy, a_done} !== 3'b101) begin
            miscompares++;
            $display("FAIL rst_after_done got=%b want=101", {a_out, a_busy, a_done});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_even();
        test_odd_two_stop();
        test_short_no_parity();
        test_busy_lockout();
        test_back_to_back();
        test_held_start();
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
